// File: rtl/melody_seq.sv
// melody_seq
//
// Shares the single tone generator between the manual path (encoder
// frequency plus mute button) and an internal 8-note melody player.
// While a melody plays, the player owns the tone generator. Otherwise the
// manual request is passed through with one cycle of latency.
//
// Parameters:
//   TICK_DIV    clock cycles per duration tick (>= 2)
//   NOTE_TICKS  ticks each note sounds (1..65535)
//   GAP_TICKS   silent ticks after each note (1..65535)
//
// Ports:
//   clk          system clock
//   reset_n      synchronous, active-low reset
//   start        single-cycle pulse, begins the melody from IDLE
//   stop         single-cycle pulse, aborts a running melody
//   loop         level, sampled when the last gap ends
//   manual_freq  manual frequency in Hz
//   manual_on    manual tone enable
//   freq         frequency to the tone generator, in Hz (registered)
//   onOff        tone enable to the tone generator (registered)
//   busy         high while the melody owns the tone generator (registered)
//   note_idx     index of the current note (registered)

module melody_seq #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned NOTE_TICKS = 250,
    parameter int unsigned GAP_TICKS  = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [31:0] manual_freq,
    input  logic        manual_on,
    output logic [31:0] freq,
    output logic        onOff,
    output logic        busy,
    output logic [2:0]  note_idx
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [15:0]   NOTE_LAST  = 16'(NOTE_TICKS - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [15:0] tick_cnt;
    logic [15:0] tick_next;
    logic [2:0]  note_next;
    logic [31:0] freq_next;
    logic        on_next;
    logic        busy_next;
    logic        tick;

    // Fixed note table (C major scale, C4..C5), zero-extended to 32 bits.
    function automatic logic [31:0] note_freq(input logic [2:0] idx);
        logic [31:0] f;
        case (idx)
            3'd0:    f = 32'd262;
            3'd1:    f = 32'd294;
            3'd2:    f = 32'd330;
            3'd3:    f = 32'd349;
            3'd4:    f = 32'd392;
            3'd5:    f = 32'd440;
            3'd6:    f = 32'd494;
            default: f = 32'd523;
        endcase
        return f;
    endfunction

    // The prescaler only runs while the melody owns the generator.
    assign tick = (state != IDLE) && (presc == PRESC_LAST);

    // Next-state logic. stop is checked before the terminal tick so it
    // always wins, and start is only honoured from IDLE.
    always_comb begin
        state_next = state;
        note_next  = note_idx;
        presc_next = tick ? '0 : presc + PRESC_ONE;
        tick_next  = tick ? tick_cnt + 16'd1 : tick_cnt;

        case (state)
            IDLE: begin
                presc_next = '0;
                tick_next  = '0;
                note_next  = 3'd0;
                if (start && !stop) begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_next = IDLE;
                    note_next  = 3'd0;
                end else if (tick && tick_cnt == NOTE_LAST) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (stop) begin
                    state_next = IDLE;
                    note_next  = 3'd0;
                end else if (tick && tick_cnt == GAP_LAST) begin
                    if (note_idx != 3'd7) begin
                        state_next = PLAY;
                        note_next  = note_idx + 3'd1;
                    end else if (loop) begin
                        state_next = PLAY;
                        note_next  = 3'd0;
                    end else begin
                        state_next = IDLE;
                        note_next  = 3'd0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                note_next  = 3'd0;
            end
        endcase

        // GAP->PLAY on a loop wrap counts as a state change too, so the
        // next note always starts with fresh counters.
        if (state_next != state) begin
            presc_next = '0;
            tick_next  = '0;
        end
    end

    // Outputs are derived from the next state so the registered outputs
    // line up with the registered state.
    always_comb begin
        freq_next = manual_freq;
        on_next   = manual_on;
        busy_next = 1'b0;
        case (state_next)
            PLAY: begin
                freq_next = note_freq(note_next);
                on_next   = 1'b1;
                busy_next = 1'b1;
            end
            GAP: begin
                freq_next = note_freq(note_next);
                on_next   = 1'b0;
                busy_next = 1'b1;
            end
            default: begin
                freq_next = manual_freq;
                on_next   = manual_on;
                busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            presc    <= '0;
            tick_cnt <= '0;
            note_idx <= 3'd0;
            freq     <= 32'd0;
            onOff    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            presc    <= presc_next;
            tick_cnt <= tick_next;
            note_idx <= note_next;
            freq     <= freq_next;
            onOff    <= on_next;
            busy     <= busy_next;
        end
    end

endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq
//
// Self-checking bench for melody_seq with TICK_DIV=2, NOTE_TICKS=3,
// GAP_TICKS=1 (each note: 6 cycles sounding, 2 cycles silent).
// A fixed vector table covers reset and the first note, directed
// sequences cover the multi-cycle corner cases, and a random phase is
// checked against a position-in-melody reference model.

module tb_melody_seq;

    localparam int TD         = 2;
    localparam int NT         = 3;
    localparam int GT         = 1;
    localparam int PLAY_LEN   = NT * TD;
    localparam int NOTE_LEN   = (NT + GT) * TD;
    localparam int MELODY_LEN = 8 * NOTE_LEN;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        loop;
    logic [31:0] manual_freq;
    logic        manual_on;
    logic [31:0] freq;
    logic        onOff;
    logic        busy;
    logic [2:0]  note_idx;

    int assertCount = 0;
    int failCount   = 0;

    melody_seq #(
        .TICK_DIV   (TD),
        .NOTE_TICKS (NT),
        .GAP_TICKS  (GT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .manual_freq (manual_freq),
        .manual_on   (manual_on),
        .freq        (freq),
        .onOff       (onOff),
        .busy        (busy),
        .note_idx    (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the melody is a position counter 0..MELODY_LEN-1;
    // note and tone enable follow from plain division of that position.
    int unsigned rom [8] = '{262, 294, 330, 349, 392, 440, 494, 523};
    bit          mActive = 1'b0;
    int          mPos    = 0;
    logic [31:0] mFreq;
    logic        mOn;
    logic        mBusy;
    logic [2:0]  mNote;

    logic        curLoop = 1'b0;
    logic [31:0] curMf   = 32'd0;
    logic        curMon  = 1'b0;

    typedef struct {
        logic        rst_n;
        logic        st;
        logic        sp;
        logic        lp;
        logic [31:0] mf;
        logic        mo;
        logic [31:0] efreq;
        logic        eon;
        logic        ebusy;
        logic [2:0]  enote;
    } vec_t;

    vec_t vecs [17];

    task automatic modelStep(input logic r, input logic s, input logic p,
                             input logic l, input logic [31:0] mf,
                             input logic mo);
        int n;
        if (!r) begin
            mActive = 1'b0;
            mPos    = 0;
        end else if (mActive) begin
            if (p) begin
                mActive = 1'b0;
            end else if (mPos == MELODY_LEN - 1) begin
                if (l) mPos = 0;
                else mActive = 1'b0;
            end else begin
                mPos++;
            end
        end else if (s && !p) begin
            mActive = 1'b1;
            mPos    = 0;
        end

        if (!r) begin
            mFreq = 32'd0;
            mOn   = 1'b0;
            mBusy = 1'b0;
            mNote = 3'd0;
        end else if (mActive) begin
            n     = mPos / NOTE_LEN;
            mNote = 3'(n);
            mFreq = 32'(rom[n]);
            mOn   = (mPos % NOTE_LEN) < PLAY_LEN;
            mBusy = 1'b1;
        end else begin
            mFreq = mf;
            mOn   = mo;
            mBusy = 1'b0;
            mNote = 3'd0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic l, input logic [31:0] mf,
                                 input logic mo);
        reset_n     = r;
        start       = s;
        stop        = p;
        loop        = l;
        manual_freq = mf;
        manual_on   = mo;
        @(posedge clk);
        modelStep(r, s, p, l, mf, mo);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] ef,
                               input logic eon, input logic ebusy,
                               input logic [2:0] enote);
        assertCount += 4;
        if (freq !== ef) begin
            failCount++;
            $display("[TB] FAIL %s freq: got %0d expected %0d", name, freq, ef);
        end
        if (onOff !== eon) begin
            failCount++;
            $display("[TB] FAIL %s onOff: got %b expected %b", name, onOff, eon);
        end
        if (busy !== ebusy) begin
            failCount++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, busy, ebusy);
        end
        if (note_idx !== enote) begin
            failCount++;
            $display("[TB] FAIL %s note_idx: got %0d expected %0d", name, note_idx, enote);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mFreq, mOn, mBusy, mNote);
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        assertCount++;
        if (got != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, curLoop, curMf, curMon);
            checkModel(name);
        end
    endtask

    task automatic pulse(input logic s, input logic p, input string name);
        applyStimulus(1'b1, s, p, curLoop, curMf, curMon);
        checkModel(name);
    endtask

    initial begin
        int busyCount;
        int onCount;
        int dropped;
        int waited;

        reset_n     = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        loop        = 1'b0;
        manual_freq = 32'd0;
        manual_on   = 1'b0;

        // {rst_n, start, stop, loop, manual_freq, manual_on,
        //  exp freq, exp onOff, exp busy, exp note_idx}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1000, 1'b1, 32'd0,    1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1000, 1'b1, 32'd0,    1'b0, 1'b0, 3'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1000, 1'b1, 32'd0,    1'b0, 1'b0, 3'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd1000, 1'b1, 32'd1000, 1'b1, 1'b0, 3'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd777,  1'b0, 32'd777,  1'b0, 1'b0, 3'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd777,  1'b0, 32'd777,  1'b0, 1'b0, 3'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd777,  1'b0, 32'd777,  1'b0, 1'b0, 3'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd777,  1'b0, 32'd262,  1'b1, 1'b1, 3'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5,    1'b1, 32'd262,  1'b1, 1'b1, 3'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd5,    1'b1, 32'd262,  1'b1, 1'b1, 3'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5,    1'b1, 32'd262,  1'b1, 1'b1, 3'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5,    1'b1, 32'd262,  1'b1, 1'b1, 3'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5,    1'b1, 32'd262,  1'b1, 1'b1, 3'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5,    1'b1, 32'd262,  1'b0, 1'b1, 3'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5,    1'b1, 32'd262,  1'b0, 1'b1, 3'd0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5,    1'b1, 32'd294,  1'b1, 1'b1, 3'd1};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd5,    1'b1, 32'd5,    1'b1, 1'b0, 3'd0};

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].st, vecs[i].sp, vecs[i].lp,
                          vecs[i].mf, vecs[i].mo);
            checkOutput($sformatf("vec%0d", i), vecs[i].efreq, vecs[i].eon,
                        vecs[i].ebusy, vecs[i].enote);
        end

        // Single melody without loop: busy for exactly 64 cycles.
        curLoop = 1'b0;
        curMf   = 32'd1234;
        curMon  = 1'b1;
        run(2, "idle_pre");
        pulse(1'b1, 1'b0, "single_start");
        busyCount = busy ? 1 : 0;
        onCount   = onOff ? 1 : 0;
        for (int i = 0; i < MELODY_LEN + 6; i++) begin
            run(1, "single");
            if (busy) busyCount++;
            if (busy && onOff) onCount++;
        end
        checkValue("single_busy_cycles", busyCount, MELODY_LEN);
        checkValue("single_on_cycles", onCount, 8 * PLAY_LEN);
        checkValue("single_end_freq", int'(freq), 1234);

        // Loop: no idle cycle at the wrap, then clear loop on the second pass.
        curLoop = 1'b1;
        pulse(1'b1, 1'b0, "loop_start");
        dropped = 0;
        for (int i = 0; i < MELODY_LEN; i++) begin
            run(1, "loop_pass1");
            if (!busy) dropped++;
        end
        checkOutput("loop_cycle65", 32'd262, 1'b1, 1'b1, 3'd0);
        checkValue("loop_busy_drops", dropped, 0);
        run(20, "loop_pass2");
        curLoop = 1'b0;
        waited = 0;
        while (busy && waited < 100) begin
            run(1, "loop_end");
            waited++;
        end
        checkValue("loop_end_busy", int'(busy), 0);
        checkValue("loop_end_cycles", waited, MELODY_LEN - 20);

        // Stop on the third cycle of note 4, then restart.
        pulse(1'b1, 1'b0, "stop_start");
        run(4 * NOTE_LEN + 2, "stop_run");
        checkValue("stop_pre_freq", int'(freq), 392);
        pulse(1'b0, 1'b1, "stop_pulse");
        checkOutput("stop_after", 32'd1234, 1'b1, 1'b0, 3'd0);
        pulse(1'b1, 1'b0, "stop_restart");
        checkOutput("stop_restart_chk", 32'd262, 1'b1, 1'b1, 3'd0);
        pulse(1'b0, 1'b1, "stop_restart_abort");

        // start during PLAY is ignored; timing continues unchanged.
        pulse(1'b1, 1'b0, "conf_start");
        run(2, "conf_play");
        pulse(1'b1, 1'b0, "conf_restart_ignored");
        run(NOTE_LEN, "conf_follow");
        checkOutput("conf_note1", 32'd294, 1'b1, 1'b1, 3'd1);
        pulse(1'b0, 1'b1, "conf_abort");

        // stop on the GAP-terminal cycle goes to IDLE rather than PLAY.
        pulse(1'b1, 1'b0, "gapstop_start");
        run(NOTE_LEN - 1, "gapstop_run");
        pulse(1'b0, 1'b1, "gapstop_pulse");
        checkOutput("gapstop_idle", 32'd1234, 1'b1, 1'b0, 3'd0);

        // Reset during the gap of note 2.
        pulse(1'b1, 1'b0, "rstmid_start");
        run(2 * NOTE_LEN + PLAY_LEN, "rstmid_run");
        checkValue("rstmid_in_gap", int'(onOff), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, curLoop, curMf, curMon);
        checkOutput("rstmid_reset", 32'd0, 1'b0, 1'b0, 3'd0);
        run(5, "rstmid_idle");
        checkValue("rstmid_stays_idle", int'(busy), 0);

        // Random phase against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic s;
            logic p;
            r = ($urandom_range(0, 399) != 0);
            s = ($urandom_range(0, 24) == 0);
            p = ($urandom_range(0, 89) == 0);
            if ($urandom_range(0, 49) == 0) curLoop = ~curLoop;
            if ($urandom_range(0, 3) == 0) curMf = $urandom;
            curMon = 1'($urandom);
            applyStimulus(r, s, p, curLoop, curMf, curMon);
            checkModel("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/melody_seq.md
# melody_seq

Melody sequencer and arbiter for the single tone generator. It shares `tonegen`'s `freq`/`onOff` inputs between two requesters: the manual path (encoder frequency and mute button) and an internal 8-note melody player. While a melody plays, the player owns the tone generator. Otherwise the manual request passes through. It sits between `enc2freq` and `tonegen` in the lab top level, and its `freq` output also feeds the 7-segment display mux.

## Interface
- `TICK_DIV`, 50000: clock cycles per duration tick (1 ms at 50 MHz); must be ≥ 2.
- `NOTE_TICKS`, 250: ticks each note sounds; must be ≥ 1, and ≤ 65535.
- `GAP_TICKS`, 20: silent ticks after each note; must be ≥ 1, and ≤ 65535.
- `clk`  in  1  system clock (CLOCK_50).
- `reset_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  single-cycle pulse: begin melody.
- `stop`  in  1  single-cycle pulse: abort melody.
- `loop`  in  1  level; sampled at the end of the last gap.
- `manual_freq`  in  32  manual frequency in Hz (from `enc2freq`).
- `manual_on`  in  1  manual tone enable.
- `freq`  out  32  frequency to `tonegen`, in Hz.
- `onOff`  out  1  tone enable to `tonegen`.
- `busy`  out  1  high while the melody owns the tone generator.
- `note_idx`  out  3  index of the current note.

## Operation
- **Note table:** a fixed internal ROM, index 0..7 = 262, 294, 330, 349, 392, 440, 494, 523 Hz. It is zero-extended to 32 bits.
- **States:** IDLE, PLAY, GAP.
- **IDLE**
  - Outputs: `freq`=`manual_freq`, `onOff`=`manual_on`, `busy`=0, `note_idx`=0.
  - `start` → PLAY, with `note_idx`=0 and all counters cleared.
- **PLAY**
  - Outputs: `freq`=ROM[`note_idx`], `onOff`=1, `busy`=1.
  - After NOTE_TICKS ticks → GAP.
- **GAP**
  - Outputs: `freq` holds ROM[`note_idx`], `onOff`=0, `busy`=1.
  - After GAP_TICKS ticks, if `note_idx`<7: `note_idx`+1 → PLAY.
  - After GAP_TICKS ticks, if `note_idx`=7 and `loop`=1: `note_idx`=0 → PLAY.
  - After GAP_TICKS ticks, if `note_idx`=7 and `loop`=0: → IDLE.
- **Prescaler:** counts 0..TICK_DIV-1 and produces a tick on the terminal count. It clears on every state change and holds at 0 in IDLE.
- **Tick counter:** 16-bit. It clears on every state change. The state is left on the tick where tick_cnt = (limit − 1).
- **`stop`:** in PLAY or GAP, `stop` → IDLE next cycle with `note_idx`=0 and counters cleared. In IDLE it has no effect.
- **Simultaneous events:**
  - `start` in PLAY or GAP is ignored. No restart occurs.
  - `start` and `stop` in the same cycle: `stop` wins. From IDLE, the block stays in IDLE.
  - `stop` in the same cycle as a state-terminal tick: `stop` wins and the block goes to IDLE.
- **Manual inputs during a melody:** changes on `manual_freq` and `manual_on` during PLAY or GAP are ignored. They are reflected again one cycle after returning to IDLE.
- **Reset:** `reset_n`=0 at any time, including mid-note, sets the following on the next edge:
  - state IDLE
  - `freq`=0, `onOff`=0, `busy`=0, `note_idx`=0
  - prescaler and tick counter 0
- **Output registers:** all outputs are registered. The output values are computed from the next state, so the outputs always match the current state.

## Timing
- **`start` sampled at edge N in IDLE:** at edge N+1, `busy`=1, `onOff`=1, and `freq`=262.
- **Note length:** PLAY lasts exactly NOTE_TICKS×TICK_DIV cycles. GAP lasts exactly GAP_TICKS×TICK_DIV cycles.
- **Full melody:** 8×(NOTE_TICKS+GAP_TICKS)×TICK_DIV cycles from the first `busy`=1 cycle to the first `busy`=0 cycle.
- **`stop` sampled at edge N:** at edge N+1, `busy`=0 and `onOff`=`manual_on`.
- **Manual pass-through in IDLE:** 1-cycle latency from `manual_freq`/`manual_on` to `freq`/`onOff`.
- **Loop wrap:** there is no idle cycle between note 7's GAP and note 0's PLAY.

## Test plan
All scenarios use TICK_DIV=2, NOTE_TICKS=3, GAP_TICKS=1 (each note: PLAY 6 cycles, then GAP 2 cycles).
- **Reset:** hold `reset_n`=0 for 3 cycles with `manual_freq`=1000 → `freq`=0, `onOff`=0, `busy`=0, `note_idx`=0. Release → next cycle `freq`=1000 and `onOff` equals `manual_on`.
- **Single melody, `loop`=0:** pulse `start` →
  - `onOff` pattern is 6 high / 2 low, repeated 8 times.
  - `freq` steps 262, 294, …, 523; `note_idx` steps 0..7.
  - `busy` is high for exactly 64 cycles, then returns to `freq`=`manual_freq`.
- **Loop:** `loop`=1, pulse `start` → at cycle 65 `note_idx`=0, `freq`=262, `onOff`=1, and `busy` never drops. Set `loop`=0 during the second pass → the melody ends after `note_idx` 7.
- **Stop mid-note:** pulse `stop` on the 3rd cycle of note 4 (`freq`=392) → next cycle `busy`=0, `note_idx`=0, `freq`=`manual_freq`. A following `start` restarts at 262.
- **Conflicts:**
  - `start` during PLAY → no change to `note_idx` or timing.
  - `start`+`stop` in the same cycle from IDLE → stays IDLE.
  - `stop` on the GAP-terminal cycle → IDLE, not PLAY.
- **Reset mid-melody:** assert `reset_n`=0 for 1 cycle during GAP of note 2 → next cycle all outputs at reset values. After release, the block stays IDLE until `start`.
